// File: rtl/seq_mult_param.sv
// -----------------------------------------------------------------------------
// seq_mult_param
//   Radix-2 shift-add sequential multiplier with WIDTH-bit operands and a
//   2*WIDTH-bit product. Each operation selects signed or unsigned arithmetic.
//   Operands are turned into magnitudes when the operation is accepted, WIDTH
//   add/shift iterations run, and the sign is applied in one final cycle.
//   Latency is WIDTH+1 cycles from the accept edge to out_valid, for any
//   operand values.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     operands and mode are valid
//   in_ready     block can accept an operation (IDLE only)
//   in1          multiplicand, WIDTH bits
//   in2          multiplier, WIDTH bits
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   out_valid    result is valid
//   out_ready    consumer accepts the result
//   result       product, 2*WIDTH bits
//   dbg_state_o  current FSM state (0 IDLE, 1 CALC, 2 SIGN, 3 DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Input side: in_ready is high only in IDLE; in_valid is ignored
// in every other state and is not queued. Output side: out_valid stays high
// and result stays stable until an edge with out_ready high. out_ready has
// no effect while out_valid is low.
// -----------------------------------------------------------------------------
module seq_mult_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W     = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W    = (2*WIDTH)'(1);

  state_e               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [2*WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]     mcand_q;   // multiplicand magnitude
  logic [WIDTH-1:0]     mplier_q;  // multiplier magnitude, consumed LSB first
  logic [2*WIDTH:0]     acc_q;     // bit 2*WIDTH holds the carry of the add
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_q;

  logic [WIDTH-1:0]     mag1_d;
  logic [WIDTH-1:0]     mag2_d;
  logic                 neg_d;
  logic [WIDTH:0]       upper_sum_d;
  logic [2*WIDTH:0]     acc_added_d;
  logic [2*WIDTH:0]     acc_d;
  logic [2*WIDTH-1:0]   result_d;

  // Magnitudes at accept. The most-negative value negates to 2^(WIDTH-1),
  // which is still representable as an unsigned WIDTH-bit magnitude.
  always_comb begin
    mag1_d = in1;
    mag2_d = in2;
    if (signed_mode && in1[WIDTH-1]) mag1_d = (~in1) + ONE_W;
    if (signed_mode && in2[WIDTH-1]) mag2_d = (~in2) + ONE_W;
    neg_d = signed_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);
  end

  // One iteration: conditional add into the upper half, then shift right.
  // acc_q[2*WIDTH] is always zero entering an iteration (it was shifted out),
  // so the upper slice add cannot overflow WIDTH+1 bits.
  always_comb begin
    upper_sum_d = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
    acc_added_d = acc_q;
    if (mplier_q[0]) acc_added_d = {upper_sum_d, acc_q[WIDTH-1:0]};
    acc_d = {1'b0, acc_added_d[2*WIDTH:1]};
  end

  // Sign fix-up. A zero magnitude negates back to zero.
  always_comb begin
    result_d = acc_q[2*WIDTH-1:0];
    if (neg_q) result_d = (~acc_q[2*WIDTH-1:0]) + ONE_2W;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mcand_q    <= mag1_d;
            mplier_q   <= mag2_d;
            neg_q      <= neg_d;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) state_q <= S_SIGN;
        end
        S_SIGN: begin
          result_q    <= result_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          // result_q is left untouched so the last product stays visible.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_param
//   Drives a WIDTH=32 and a WIDTH=8 instance of seq_mult_param with directed
//   operations followed by random operations in both modes. Expected products
//   are pushed to a per-instance queue when an operation is driven and popped
//   when the instance raises out_valid.
// -----------------------------------------------------------------------------
module tb_seq_mult_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- WIDTH=32 instance ----------------
  logic        in_valid32, in_ready32, signed_mode32, out_valid32, out_ready32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic [1:0]  st32;

  seq_mult_param #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .in1(a32), .in2(b32), .signed_mode(signed_mode32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .result(res32), .dbg_state_o(st32)
  );

  // ---------------- WIDTH=8 instance ----------------
  logic        in_valid8, in_ready8, signed_mode8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic [1:0]  st8;

  seq_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in1(a8), .in2(b8), .signed_mode(signed_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .result(res8), .dbg_state_o(st8)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp32_q[$];
  logic [15:0] exp8_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    logic signed [15:0] sp;
    logic [15:0]        up;
    sp = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
    up = {8'd0, a} * {8'd0, b};
    return sm ? sp : up;
  endfunction

  // ---------------- driver tasks ----------------
  // Issue one op on the 32-bit instance; scramble inputs while busy, hold
  // out_ready low for `hold` cycles once the result appears, then consume.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                       input logic [63:0] exp, input int hold);
    int n;
    logic [63:0] e;
    logic [63:0] held;
    n = 0;
    while (in_ready32 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("in_ready32_idle", 64'(in_ready32), 64'(1));
    a32 = a; b32 = b; signed_mode32 = sm; in_valid32 = 1'b1;
    exp32_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    in_valid32 = 1'b0;
    n = 0;
    while (out_valid32 !== 1'b1 && n < 100) begin
      chk("in_ready32_busy", 64'(in_ready32), 64'(0));
      a32 = $urandom; b32 = $urandom;
      signed_mode32 = ~signed_mode32;
      in_valid32 = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    in_valid32 = 1'b0;
    chk("latency32", 64'(n), 64'(33));
    e = exp32_q.pop_front();
    chk("result32", res32, e);
    held = res32;
    for (int i = 0; i < hold; i++) begin
      out_ready32 = 1'b0;
      in_valid32 = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold32_valid", 64'(out_valid32), 64'(1));
      chk("hold32_result", res32, held);
      chk("hold32_in_ready", 64'(in_ready32), 64'(0));
    end
    in_valid32 = 1'b0;
    out_ready32 = 1'b1;
    @(negedge clk);
    chk("consume32_valid", 64'(out_valid32), 64'(0));
    chk("consume32_in_ready", 64'(in_ready32), 64'(1));
    chk("consume32_result_kept", res32, held);
    out_ready32 = 1'b0;
  endtask

  // Issue one op on the 8-bit instance; `tie` leaves out_ready high so ops
  // run back to back.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input logic [15:0] exp, input logic tie);
    int n;
    logic [15:0] e;
    n = 0;
    while (in_ready8 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("in_ready8_idle", 64'(in_ready8), 64'(1));
    a8 = a; b8 = b; signed_mode8 = sm; in_valid8 = 1'b1;
    exp8_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    n = 0;
    while (out_valid8 !== 1'b1 && n < 100) begin
      chk("in_ready8_busy", 64'(in_ready8), 64'(0));
      a8 = 8'($urandom); b8 = 8'($urandom);
      signed_mode8 = ~signed_mode8;
      @(negedge clk);
      n++;
    end
    chk("latency8", 64'(n), 64'(9));
    e = exp8_q.pop_front();
    chk("result8", 64'(res8), 64'(e));
    out_ready8 = 1'b1;
    @(negedge clk);
    chk("consume8_valid", 64'(out_valid8), 64'(0));
    chk("consume8_in_ready", 64'(in_ready8), 64'(1));
    out_ready8 = tie;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] ra, rb;
    reset = 1'b1;
    in_valid32 = 1'b0; out_ready32 = 1'b0; signed_mode32 = 1'b0; a32 = '0; b32 = '0;
    in_valid8  = 1'b0; out_ready8  = 1'b0; signed_mode8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("reset32_in_ready", 64'(in_ready32), 64'(1));
    chk("reset32_out_valid", 64'(out_valid32), 64'(0));
    chk("reset32_result", res32, 64'(0));
    chk("reset32_state", 64'(st32), 64'(0));
    chk("reset8_in_ready", 64'(in_ready8), 64'(1));
    chk("reset8_result", 64'(res8), 64'(0));

    // Arithmetic corners
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0);
    run32(32'hFFFF_FFFD, 32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 0);
    run32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0);
    run32(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 0);
    run32(32'd0,         32'hFFFF_FFF9, 1'b1, 64'd0, 0);
    // Operand isolation: inputs scrambled during CALC by the driver
    run32(32'd7, 32'd9, 1'b0, 64'd63, 0);
    // Backpressure, then an immediate follow-up op
    run32(32'd1234, 32'd5678, 1'b0, 64'd7006652, 10);
    run32(32'hFFFF_FFFF, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0);

    // Reset during CALC iteration 10
    @(negedge clk);
    a32 = 32'd100; b32 = 32'd200; signed_mode32 = 1'b0; in_valid32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid32 = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset_state", 64'(st32), 64'(1));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_in_ready", 64'(in_ready32), 64'(1));
    chk("midreset_out_valid", 64'(out_valid32), 64'(0));
    chk("midreset_result", res32, 64'(0));
    run32(32'd12, 32'd12, 1'b0, 64'd144, 0);

    // WIDTH=8 corner, then random in both modes back to back
    run8(8'h80, 8'h7F, 1'b1, 16'hC080, 1'b0);
    run8(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0);
    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0);
    out_ready8 = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 1000; k++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        run8(ra, rb, 1'(m), model8(ra, rb, 1'(m)), 1'b1);
      end
    end
    out_ready8 = 1'b0;

    chk("queue32_drained", 64'(exp32_q.size()), 64'(0));
    chk("queue8_drained", 64'(exp8_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
